// File: rtl/idecode.sv
// Instruction-decode stage of the 5-stage RV32I pipeline: decodes InstrD, reads the
// register file with write-through bypass, extends the immediate and registers it all into ID/EX.
module idecode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rdd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] rd1, rd2, immext;
  logic            regwrite, memwrite, jump, branch, alusrc;
  logic [1:0]      resultsrc;
  logic [2:0]      aluctl, alu_dec;
  logic            wb_active;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign rdd      = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  // funct3-driven ALU op for R-type and I-ALU; only R-type may turn add into sub
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    alusrc    = 1'b0;
    resultsrc = 2'b00;
    aluctl    = ALU_ADD;
    immext    = '0;
    case (opcode)
      OP_LW: begin
        regwrite  = 1'b1;
        alusrc    = 1'b1;
        resultsrc = 2'b01;
        immext    = imm_i;
      end
      OP_SW: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        immext   = imm_s;
      end
      OP_R: begin
        regwrite = 1'b1;
        aluctl   = alu_dec;
      end
      OP_I: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = alu_dec;
        immext   = imm_i;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluctl = ALU_SUB;
        immext = imm_b;
      end
      OP_JAL: begin
        regwrite  = 1'b1;
        jump      = 1'b1;
        resultsrc = 2'b10;
        immext    = imm_j;
      end
      default: ;
    endcase
  end

  // Same-cycle writeback is forwarded so the write can land on the rising edge
  assign wb_active = RegWriteW && (RdW != 5'd0);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != 5'd0) rd1 = (wb_active && RdW == Rs1D) ? ResultW : rf[Rs1D];
    if (Rs2D != 5'd0) rd2 = (wb_active && RdW == Rs2D) ? ResultW : rf[Rs2D];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_active) begin
      rf[RdW] <= ResultW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= immext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rdd;
      RegWriteE   <= regwrite;
      MemWriteE   <= memwrite;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alusrc;
      ResultSrcE  <= resultsrc;
      ALUControlE <= aluctl;
    end
  end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Instruction-decode (ID) stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes InstrD/PCD/PCPlus4D from the IF/ID register and holds the 32x32 register file, which is written from the writeback stage.
- Decodes control signals, reads operands and extends the immediate.
- Registers everything into the ID/EX pipeline register for the execute stage.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register-file depth (index width 5).

Ports:
- clk  input  1  stage clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- InstrD  input  32  instruction from the IF/ID register.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PCD+4.
- RegWriteW  input  1  writeback enable.
- RdW  input  5  writeback destination.
- ResultW  input  32  writeback data.
- FlushE  input  1  insert a bubble into ID/EX (branch taken or load-use).
- Rs1D, Rs2D  output  5 each  combinational source indices for the hazard unit.
- RD1E, RD2E  output  32 each  registered operands.
- ImmExtE  output  32  registered extended immediate.
- PCE, PCPlus4E  output  32 each  registered PC values.
- Rs1E, Rs2E, RdE  output  5 each  registered register indices.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control.
- ResultSrcE  output  2  00=ALU, 01=memory, 10=PC+4.
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset=1, every E output becomes 0.
  - All 32 registers clear to 0.
- Latency: one cycle. Values decoded from InstrD in cycle N appear on the E outputs after edge N+1.
- Field extraction:
  - Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], rd=InstrD[11:7].
  - These pass to Rs1E, Rs2E, RdE unmodified, including for formats that do not use them.
- Decoder (opcode InstrD[6:0]):
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, add.
  - sw 0100011: MemWrite, ALUSrc, add.
  - R-type 0110011: RegWrite.
  - I-ALU 0010011: RegWrite, ALUSrc.
  - beq 1100011: Branch, sub.
  - jal 1101111: RegWrite, Jump, ResultSrc=10.
  - Any other opcode: all control 0 (bubble).
- ALU decode from funct3/funct7[5]:
  - 000 gives add.
  - 000 gives sub only for R-type with funct7[5]=1.
  - 010 gives slt, 110 gives or, 111 gives and.
  - Other funct3 gives add.
- Immediate, sign-extended from bit 31:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type and unsupported opcodes: 0.
- Register file:
  - Write on the rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; reading x0 always returns 0.
- Write-through bypass: if RegWriteW=1, RdW!=0 and RdW matches rs1/rs2, the read returns ResultW in the same cycle. This replaces the falling-edge-write scheme.
- FlushE=1 (reset=0):
  - Next edge clears all E control and data outputs to 0.
  - The register-file write still happens.
- reset and FlushE together: reset semantics apply.
- Reset mid-operation: discards in-flight ID/EX contents and architectural register state within one edge.
- No stall input: the ID/EX register updates every cycle.

Test Plan:
1. Reset: assert reset 2 cycles with random inputs -> all E outputs 0; later reads of x1..x31 return 0.
2. Writeback then read: write x5=0xDEADBEEF; next cycle InstrD=0x00528333 (add x6,x5,x5) -> RD1E=RD2E=0xDEADBEEF, RegWriteE=1, ALUControlE=000, RdE=6.
3. Bypass: same cycle RegWriteW=1, RdW=7, ResultW=0x12345678 and InstrD=0x00038393 (addi x7,x7,0) -> RD1E=0x12345678, ImmExtE=0, ALUSrcE=1.
4. x0 protection: RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF; then read x0 -> RD1E=0.
5. Immediates:
   - InstrD=0xFFC42303 (lw x6,-4(x8)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01.
   - InstrD=0xFE000EE3 (beq x0,x0,-4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
   - jal x1,+8 (0x008000EF) -> ImmExtE=8, JumpE=1, ResultSrcE=10.
6. Flush: FlushE=1 with sw instruction 0x0062A223 -> next edge MemWriteE=0 and all E outputs 0; a concurrent writeback of x9 still lands.
